// File: rtl/matrix_store_scheduler.sv
// Three-requester matrix store scheduler: round-robin grant, slot allocation, element
// streaming into BRAM and commit. Define STORE_TIMEOUT_EN to add a 255-cycle write watchdog.
module matrix_store_scheduler #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int MAX_DIM       = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 req,
    input  logic [11:0]                req_m,
    input  logic [11:0]                req_n,
    input  logic [2:0]                 elem_valid,
    input  logic [3*ELEMENT_WIDTH-1:0] elem_data,
    output logic [2:0]                 elem_ready,
    output logic [2:0]                 grant,
    output logic [2:0]                 done,
    output logic [2:0]                 fail,
    output logic                       busy,
    output logic                       alloc_req,
    output logic [3:0]                 alloc_m,
    output logic [3:0]                 alloc_n,
    input  logic                       alloc_valid,
    input  logic [3:0]                 alloc_slot,
    input  logic [11:0]                alloc_addr,
    output logic                       commit_req,
    output logic [3:0]                 commit_slot,
    output logic [3:0]                 commit_m,
    output logic [3:0]                 commit_n,
    output logic [11:0]                commit_addr,
    output logic                       bram_we,
    output logic [11:0]                bram_addr,
    output logic [ELEMENT_WIDTH-1:0]   bram_wdata
);

    typedef enum logic [2:0] {IDLE, ALLOC, WAIT, WRITE, COMMIT, FINISH} state_t;

    localparam logic [3:0] MAX_D = 4'(MAX_DIM);

    state_t                     state_q, state_d;
    logic [2:0]                 grant_q, grant_d;
    logic [1:0]                 gidx_q, gidx_d;
    logic [1:0]                 ptr_q, ptr_d;
    logic [3:0]                 m_q, m_d, n_q, n_d;
    logic [3:0]                 slot_q, slot_d;
    logic [11:0]                base_q, base_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       alloc_req_q, alloc_req_d;
    logic                       commit_req_q, commit_req_d;
    logic                       bram_we_q, bram_we_d;
    logic [11:0]                bram_addr_q, bram_addr_d;
    logic [ELEMENT_WIDTH-1:0]   bram_wdata_q, bram_wdata_d;
    logic [2:0]                 done_q, done_d, fail_q, fail_d;
`ifdef STORE_TIMEOUT_EN
    logic [7:0]                 wdog_q, wdog_d;
`endif

    logic                       sel_found;
    logic [1:0]                 sel_idx;
    logic [2:0]                 cand;
    logic [3:0]                 sel_m, sel_n;
    logic                       sel_bad;
    logic [2:0]                 sel_oh;
    logic [7:0]                 total;
    logic                       xfer;
    logic [ELEMENT_WIDTH-1:0]   gdata;

    // Round-robin search starting at ptr_q, which always points one past the last grant.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        cand      = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cand = {1'b0, ptr_q} + 3'(i);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!sel_found && req[cand[1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[1:0];
            end
        end
    end

    assign sel_m   = req_m[{sel_idx, 2'b00} +: 4];
    assign sel_n   = req_n[{sel_idx, 2'b00} +: 4];
    assign sel_bad = (sel_m == 4'd0) || (sel_m > MAX_D) || (sel_n == 4'd0) || (sel_n > MAX_D);
    assign sel_oh  = 3'b001 << sel_idx;
    assign total   = {4'd0, m_q} * {4'd0, n_q};

    // Element handshake: the granted requester holds elem_valid with its data until a cycle
    // where elem_ready is also high; that cycle's rising edge consumes exactly one element.
    assign elem_ready = (state_q == WRITE) ? grant_q : 3'b000;
    assign xfer       = (state_q == WRITE) && elem_valid[gidx_q];
    assign gdata      = elem_data[gidx_q * ELEMENT_WIDTH +: ELEMENT_WIDTH];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        ptr_d        = ptr_q;
        m_d          = m_q;
        n_d          = n_q;
        slot_d       = slot_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        alloc_req_d  = 1'b0;
        commit_req_d = 1'b0;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        done_d       = 3'b000;
        fail_d       = 3'b000;
`ifdef STORE_TIMEOUT_EN
        wdog_d       = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (sel_found) begin
                    m_d   = sel_m;
                    n_d   = sel_n;
                    ptr_d = (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
                    if (sel_bad) begin
                        fail_d = sel_oh;
                    end else begin
                        grant_d     = sel_oh;
                        gidx_d      = sel_idx;
                        alloc_req_d = 1'b1;
                        state_d     = ALLOC;
                    end
                end
            end
            ALLOC: state_d = WAIT;
            WAIT: begin
                if (alloc_valid) begin
                    slot_d  = alloc_slot;
                    base_d  = alloc_addr;
                    state_d = WRITE;
`ifdef STORE_TIMEOUT_EN
                    wdog_d  = 8'd0;
`endif
                end else begin
                    fail_d  = grant_q;
                    grant_d = 3'b000;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (xfer) begin
                    bram_we_d    = 1'b1;
                    bram_addr_d  = base_q + {4'd0, cnt_q};
                    bram_wdata_d = gdata;
                    cnt_d        = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == total) state_d = COMMIT;
`ifdef STORE_TIMEOUT_EN
                    wdog_d       = 8'd0;
                end else if (wdog_q == 8'd254) begin
                    fail_d  = grant_q;
                    grant_d = 3'b000;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
`endif
                end
            end
            // The last element's write strobe is out during COMMIT, so commit_req follows it.
            COMMIT: begin
                commit_req_d = 1'b1;
                state_d      = FINISH;
            end
            FINISH: begin
                done_d  = grant_q;
                grant_d = 3'b000;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 3'b000;
            gidx_q       <= 2'd0;
            ptr_q        <= 2'd0;
            m_q          <= 4'd0;
            n_q          <= 4'd0;
            slot_q       <= 4'd0;
            base_q       <= 12'd0;
            cnt_q        <= 8'd0;
            alloc_req_q  <= 1'b0;
            commit_req_q <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= 12'd0;
            bram_wdata_q <= '0;
            done_q       <= 3'b000;
            fail_q       <= 3'b000;
`ifdef STORE_TIMEOUT_EN
            wdog_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            ptr_q        <= ptr_d;
            m_q          <= m_d;
            n_q          <= n_d;
            slot_q       <= slot_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            alloc_req_q  <= alloc_req_d;
            commit_req_q <= commit_req_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
`ifdef STORE_TIMEOUT_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign busy        = (state_q != IDLE);
    assign alloc_req   = alloc_req_q;
    assign alloc_m     = m_q;
    assign alloc_n     = n_q;
    assign commit_req  = commit_req_q;
    assign commit_slot = slot_q;
    assign commit_m    = m_q;
    assign commit_n    = n_q;
    assign commit_addr = base_q;
    assign bram_we     = bram_we_q;
    assign bram_addr   = bram_addr_q;
    assign bram_wdata  = bram_wdata_q;

endmodule

// File: tb/tb_matrix_store_scheduler.sv
// Self-checking bench for matrix_store_scheduler: transaction-level model with expected
// queues, a per-cycle compare process and directed store scenarios.
module tb_matrix_store_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [11:0] req_m, req_n;
    logic [2:0]  elem_valid;
    logic [23:0] elem_data;
    logic [2:0]  elem_ready, grant, done, fail;
    logic        busy, alloc_req, alloc_valid, commit_req, bram_we;
    logic [3:0]  alloc_m, alloc_n, alloc_slot, commit_slot, commit_m, commit_n;
    logic [11:0] alloc_addr, commit_addr, bram_addr;
    logic [7:0]  bram_wdata;

    matrix_store_scheduler dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_m(req_m), .req_n(req_n),
        .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready),
        .grant(grant), .done(done), .fail(fail), .busy(busy),
        .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
        .alloc_valid(alloc_valid), .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
        .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
        .commit_n(commit_n), .commit_addr(commit_addr),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [19:0] exp_wr_q[$];
    logic [23:0] exp_cm_q[$];
    logic [7:0]  exp_al_q[$];
    logic [5:0]  exp_ev_q[$];
    logic [2:0]  exp_gr_q[$];
    logic [2:0]  grant_log[$];
    int          rr_next = 0;
    int          wr_seen = 0, cm_seen = 0, al_seen = 0;
    logic [19:0] last_wr = '0;
    logic [23:0] last_cm = '0;
    int          last_cm_cyc = 0;
    logic [2:0]  cur_exp_g = 3'b000;
    logic [2:0]  prev_grant = 3'b000, prev_done = 3'b000;
    logic        prev_cm = 1'b0, prev_al = 1'b0;
    logic        mgr_accept = 1'b1, alloc_pend = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [95:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    function automatic logic [95:0] all_outs();
        return 96'({elem_ready, grant, done, fail, busy, alloc_req, alloc_m, alloc_n,
                    commit_req, commit_slot, commit_m, commit_n, commit_addr,
                    bram_we, bram_addr, bram_wdata});
    endfunction

    // ---------------- behavioural model ----------------
    task automatic rr_pick(input logic [2:0] mask, output int r);
        r = -1;
        for (int i = 0; i < 3; i++) begin
            int c;
            c = (rr_next + i) % 3;
            if (r < 0 && mask[c]) r = c;
        end
        rr_next = (r + 1) % 3;
    endtask

    // stop < 0: complete store; stop >= 0: only that many writes happen before an abort.
    task automatic expect_store(input logic [2:0] mask, input int m, input int n,
                                input bit accept, input logic [3:0] slot,
                                input logic [11:0] base, input logic [7:0] d0,
                                input int stop, output int r);
        logic [2:0] oh;
        int total;
        rr_pick(mask, r);
        oh = 3'(1 << r);
        if (m < 1 || m > 5 || n < 1 || n > 5) begin
            exp_ev_q.push_back({3'b000, oh});
        end else begin
            exp_gr_q.push_back(oh);
            exp_al_q.push_back({4'(m), 4'(n)});
            if (!accept) begin
                exp_ev_q.push_back({3'b000, oh});
            end else begin
                total = (stop >= 0) ? stop : m * n;
                for (int i = 0; i < total; i++)
                    exp_wr_q.push_back({12'(base + 12'(i)), 8'(d0 + 8'(i))});
                if (stop < 0) begin
                    exp_cm_q.push_back({slot, 4'(m), 4'(n), base});
                    exp_ev_q.push_back({oh, 3'b000});
                end
            end
        end
    endtask

    // ---------------- allocation manager: answers one cycle after alloc_req ----------------
    always @(negedge clk) begin
        alloc_valid = alloc_pend & mgr_accept;
        alloc_pend  = rst_n & alloc_req;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_we) begin
                wr_seen++;
                last_wr = {bram_addr, bram_wdata};
                if (exp_wr_q.size() == 0) flag("bram_write_extra", 96'(last_wr));
                else check("bram_write", 96'(last_wr), 96'(exp_wr_q.pop_front()));
            end
            if (commit_req) begin
                cm_seen++;
                last_cm = {commit_slot, commit_m, commit_n, commit_addr};
                last_cm_cyc = cyc;
                check("commit_after_all_writes", 96'(exp_wr_q.size()), 96'(0));
                if (exp_cm_q.size() == 0) flag("commit_extra", 96'(last_cm));
                else check("commit", 96'(last_cm), 96'(exp_cm_q.pop_front()));
                if (bram_we) flag("commit_with_bram_we", 96'(bram_addr));
                if (prev_cm) flag("commit_not_single", 96'(1));
            end
            if (alloc_req) begin
                al_seen++;
                check("elem_ready_in_alloc", 96'(elem_ready), 96'(0));
                if (prev_al) flag("alloc_not_single", 96'(1));
                if (exp_al_q.size() == 0) flag("alloc_extra", 96'({alloc_m, alloc_n}));
                else check("alloc_dims", 96'({alloc_m, alloc_n}), 96'(exp_al_q.pop_front()));
            end
            if ((done | fail) != 3'b000) begin
                if (done != 3'b000) begin
                    check("done_after_commit", 96'(cyc - last_cm_cyc), 96'(1));
                    if (prev_done != 3'b000) flag("done_not_single", 96'(done));
                end
                if (exp_ev_q.size() == 0) flag("event_extra", 96'({done, fail}));
                else check("done_fail", 96'({done, fail}), 96'(exp_ev_q.pop_front()));
            end
            if (grant != 3'b000 && prev_grant == 3'b000) begin
                grant_log.push_back(grant);
                if (exp_gr_q.size() == 0) begin
                    flag("grant_extra", 96'(grant));
                    cur_exp_g = 3'b000;
                end else begin
                    cur_exp_g = exp_gr_q.pop_front();
                end
            end
            if (grant != 3'b000) check("grant", 96'(grant), 96'(cur_exp_g));
            if (busy) check("elem_ready_owner", 96'(elem_ready & ~grant), 96'(0));
            else check("elem_ready_idle", 96'(elem_ready), 96'(0));
        end
        prev_grant = rst_n ? grant : 3'b000;
        prev_done  = rst_n ? done : 3'b000;
        prev_cm    = rst_n & commit_req;
        prev_al    = rst_n & alloc_req;
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic start_req(input int r, input int m, input int n);
        req_m[r*4 +: 4] = 4'(m);
        req_n[r*4 +: 4] = 4'(n);
        req[r] = 1'b1;
        @(negedge clk);
        req[r] = 1'b0;
    endtask

    task automatic feed(input int r, input int cnt, input logic [7:0] d0,
                        input bit gaps, input int junk);
        int k, guard;
        bit xfer;
        k = 0;
        guard = 0;
        if (junk >= 0) begin
            elem_valid[junk] = 1'b1;
            elem_data[junk*8 +: 8] = 8'hEE;
        end
        elem_data[r*8 +: 8] = d0;
        elem_valid[r] = 1'b1;
        while (k < cnt && guard < 600) begin
            xfer = elem_valid[r] && elem_ready[r];
            @(negedge clk);
            guard++;
            if (xfer) begin
                k++;
                elem_data[r*8 +: 8] = 8'(d0 + 8'(k));
                if (gaps && k < cnt && $urandom_range(0, 2) == 0) elem_valid[r] = 1'b0;
            end else begin
                elem_valid[r] = 1'b1;
            end
        end
        elem_valid = 3'b000;
        if (k < cnt) flag("feed_timeout", 96'(k));
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 600) begin
            @(negedge clk);
            g++;
        end
        if (busy) flag("idle_timeout", 96'(busy));
        repeat (2) @(negedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    logic [2:0] rr_lit [4];
    int r, g, gl0, al0, wr0, cm0;

    initial begin
        #500000;
        flag("global_timeout", 96'(cyc));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rr_lit = '{3'b001, 3'b010, 3'b100, 3'b001};
        rst_n = 1'b0; req = '0; req_m = '0; req_n = '0;
        elem_valid = '0; elem_data = '0; alloc_slot = '0; alloc_addr = '0;
        repeat (3) @(negedge clk);
        #1 check("reset_outputs", all_outs(), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Requester 0 stores 2x3, data 1..6, slot 2 at 0x010.
        mgr_accept = 1'b1; alloc_slot = 4'd2; alloc_addr = 12'h010;
        expect_store(3'b001, 2, 3, 1'b1, 4'd2, 12'h010, 8'd1, -1, r);
        start_req(0, 2, 3);
        feed(0, 6, 8'd1, 1'b0, -1);
        wait_idle();
        check("t1_last_write", 96'(last_wr), 96'({12'h015, 8'h06}));
        check("t1_commit", 96'(last_cm), 96'({4'd2, 4'd2, 4'd3, 12'h010}));
        check("t1_write_count", 96'(wr_seen), 96'(6));

        // Illegal dimensions: 6x2 on requester 1, 0x3 on requester 2.
        al0 = al_seen;
        expect_store(3'b010, 6, 2, 1'b1, 4'd0, 12'h0, 8'd0, -1, r);
        start_req(1, 6, 2);
        wait_idle();
        expect_store(3'b100, 0, 3, 1'b1, 4'd0, 12'h0, 8'd0, -1, r);
        start_req(2, 0, 3);
        wait_idle();
        check("bad_dims_no_alloc", 96'(al_seen), 96'(al0));

        // Allocation refused.
        wr0 = wr_seen; cm0 = cm_seen;
        mgr_accept = 1'b0;
        expect_store(3'b010, 2, 2, 1'b0, 4'd0, 12'h0, 8'd0, -1, r);
        start_req(1, 2, 2);
        wait_idle();
        check("refused_no_write", 96'(wr_seen), 96'(wr0));
        check("refused_no_commit", 96'(cm_seen), 96'(cm0));
        mgr_accept = 1'b1;

        // Address wrap at the top of BRAM, with junk from requester 0.
        alloc_slot = 4'd9; alloc_addr = 12'hFFE;
        expect_store(3'b010, 2, 2, 1'b1, 4'd9, 12'hFFE, 8'h30, -1, r);
        start_req(1, 2, 2);
        feed(1, 4, 8'h30, 1'b1, 0);
        wait_idle();
        check("wrap_last_write", 96'(last_wr), 96'({12'h001, 8'h33}));

        // Largest legal matrix with stalls and junk from requester 1.
        alloc_slot = 4'd7; alloc_addr = 12'h100;
        expect_store(3'b100, 5, 5, 1'b1, 4'd7, 12'h100, 8'h40, -1, r);
        start_req(2, 5, 5);
        feed(2, 25, 8'h40, 1'b1, 1);
        wait_idle();
        check("max_last_write", 96'(last_wr), 96'({12'h118, 8'h58}));

        // Round robin with all three requesting 1x1 continuously.
        gl0 = grant_log.size();
        alloc_slot = 4'd1; alloc_addr = 12'h200;
        req_m = {4'd1, 4'd1, 4'd1}; req_n = {4'd1, 4'd1, 4'd1}; req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            expect_store(3'b111, 1, 1, 1'b1, 4'd1, 12'h200, 8'(8'hA0 + 8'(t)), -1, r);
            g = 0;
            while (grant == 3'b000 && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (grant == 3'b000) flag("rr_grant_timeout", 96'(t));
            if (t == 3) req = 3'b000;
            feed(r, 1, 8'(8'hA0 + 8'(t)), 1'b0, -1);
            g = 0;
            while (busy && g < 50) begin
                @(negedge clk);
                g++;
            end
        end
        wait_idle();
        for (int t = 0; t < 4; t++) begin
            if (grant_log.size() > gl0 + t) check("rr_order", 96'(grant_log[gl0 + t]), 96'(rr_lit[t]));
            else flag("rr_order_missing", 96'(t));
        end

`ifdef STORE_TIMEOUT_EN
        // Watchdog: no element for 255 cycles.
        cm0 = cm_seen;
        expect_store(3'b010, 1, 1, 1'b1, 4'd1, 12'h200, 8'h00, 0, r);
        exp_ev_q.push_back({3'b000, 3'b010});
        start_req(1, 1, 1);
        wait_idle();
        check("watchdog_no_commit", 96'(cm_seen), 96'(cm0));
`else
        // Without the watchdog, WRITE waits as long as it takes.
        expect_store(3'b010, 1, 1, 1'b1, 4'd1, 12'h200, 8'h77, -1, r);
        start_req(1, 1, 1);
        repeat (300) @(negedge clk);
        check("no_watchdog_still_busy", 96'(busy), 96'(1));
        feed(1, 1, 8'h77, 1'b0, -1);
        wait_idle();
`endif

        // Reset after 3 of 4 elements of a 2x2 store.
        cm0 = cm_seen;
        alloc_slot = 4'd4; alloc_addr = 12'h300;
        expect_store(3'b001, 2, 2, 1'b1, 4'd4, 12'h300, 8'h10, 3, r);
        start_req(0, 2, 2);
        feed(0, 3, 8'h10, 1'b0, -1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("midreset_outputs", all_outs(), 96'(0));
        rr_next = 0;
        check("midreset_writes_done", 96'(exp_wr_q.size()), 96'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_no_commit", 96'(cm_seen), 96'(cm0));

        // First request after reset: pointer back at requester 0.
        alloc_slot = 4'd5; alloc_addr = 12'h400;
        expect_store(3'b011, 1, 2, 1'b1, 4'd5, 12'h400, 8'h60, -1, r);
        req_m[3:0] = 4'd1; req_n[3:0] = 4'd2;
        req_m[7:4] = 4'd1; req_n[7:4] = 4'd2;
        req = 3'b011;
        @(negedge clk);
        req = 3'b000;
        feed(r, 2, 8'h60, 1'b0, -1);
        wait_idle();
        check("post_reset_commit", 96'(last_cm), 96'({4'd5, 4'd1, 4'd2, 12'h400}));

        check("exp_wr_empty", 96'(exp_wr_q.size()), 96'(0));
        check("exp_cm_empty", 96'(exp_cm_q.size()), 96'(0));
        check("exp_al_empty", 96'(exp_al_q.size()), 96'(0));
        check("exp_ev_empty", 96'(exp_ev_q.size()), 96'(0));
        check("exp_gr_empty", 96'(exp_gr_q.size()), 96'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_store_scheduler.md
MATRIX_STORE_SCHEDULER -- requirements
Module: matrix_store_scheduler

Interface
REQ-001 Parameters SHALL be: ELEMENT_WIDTH, 8, element bit width; MAX_DIM, 5, largest legal row/column count.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  3  per-requester store request
- req_m  in  12  rows, 4 bits per requester, requester i at [4i+3:4i]
- req_n  in  12  columns, same packing as req_m
- elem_valid  in  3  per-requester element valid
- elem_data  in  3*ELEMENT_WIDTH  per-requester element, row-major
- elem_ready  out  3  element accepted this cycle
- grant  out  3  one-hot owner of the current transaction
- done  out  3  one-cycle store-success pulse
- fail  out  3  one-cycle store-reject pulse
- busy  out  1  high whenever the FSM is not in IDLE
- alloc_req  out  1  allocation request to the matrix manager
- alloc_m, alloc_n  out  4 each  requested dimensions
- alloc_valid  in  1  manager grant, one cycle after alloc_req
- alloc_slot  in  4  slot granted by the manager
- alloc_addr  in  12  BRAM base address granted by the manager
- commit_req  out  1  commit strobe to the manager
- commit_slot  out  4  slot to commit
- commit_m, commit_n  out  4 each  dimensions to commit
- commit_addr  out  12  base address to commit
- bram_we  out  1  BRAM write enable
- bram_addr  out  12  BRAM write address
- bram_wdata  out  ELEMENT_WIDTH  BRAM write data

Function
REQ-003 FSM states SHALL be IDLE, ALLOC, WAIT, WRITE, COMMIT, FINISH.
REQ-004 In IDLE with any req bit set, the block SHALL grant one requester by round-robin, starting from the index after the last granted one (index 0 after reset), and latch that requester's m and n.
REQ-005 If the latched m or n is 0 or greater than MAX_DIM, the block SHALL pulse fail for the granted requester the next cycle, issue no alloc_req, and return to IDLE.
REQ-006 ALLOC SHALL assert alloc_req for exactly one cycle with alloc_m/alloc_n set to the latched dimensions; WAIT SHALL sample alloc_valid in the following cycle.
REQ-007 If alloc_valid is 0 in WAIT, the block SHALL pulse fail and return to IDLE; if it is 1, it SHALL latch alloc_slot and alloc_addr and enter WRITE.
REQ-008 In WRITE, elem_ready SHALL equal grant; a transfer SHALL occur when elem_valid and elem_ready of the granted requester are both high.
REQ-009 Each transfer SHALL produce bram_we=1 in the next cycle with bram_addr = base + count, bram_wdata = the transferred element, and count incrementing from 0. The count SHALL be 8 bits wide and the address sum SHALL be 12 bits wide, truncated.
REQ-010 After transfer number m*n, elem_ready SHALL drop in the next cycle and the FSM SHALL enter COMMIT.
REQ-011 COMMIT SHALL assert commit_req for one cycle with the latched slot, m, n and base address; the cycle after, FINISH SHALL pulse done for the granted requester and return to IDLE.
REQ-012 grant SHALL stay constant from the grant cycle through FINISH; req changes after the grant SHALL be ignored until IDLE.
REQ-013 elem_valid from non-granted requesters SHALL be ignored; elem_ready SHALL be 0 outside WRITE.
REQ-014 bram_we, alloc_req, commit_req, done and fail SHALL all be single-cycle registered pulses. commit_req and bram_we SHALL never be high in the same cycle.

Reset
REQ-015 While rst_n=0, the FSM SHALL be in IDLE and all outputs SHALL be 0. The round-robin pointer SHALL select requester 0 next. Counters and latches SHALL be 0.
REQ-016 A reset during any state SHALL abort the transaction with no commit_req issued. BRAM writes already made are not reverted.

Configuration
REQ-017 With STORE_TIMEOUT_EN defined, a 255-cycle watchdog SHALL run in WRITE, cleared on each transfer. On expiry the block SHALL pulse fail, skip COMMIT and return to IDLE.
REQ-018 Without STORE_TIMEOUT_EN, WRITE SHALL wait indefinitely and the watchdog logic SHALL not exist.

Verification
REQ-019 Requester 0 stores 2x3, elements 1..6, alloc_valid=1 with addr 0x010, slot 2 -> six writes to 0x010..0x015 with data 1..6, then commit_req slot=2 m=2 n=3 addr=0x010, then done[0].
REQ-020 req=3'b111 held, each store 1x1 -> grants in order 001, 010, 100, 001.
REQ-021 Requester 1 requests 6x2 with MAX_DIM=5 -> fail[1] pulse, alloc_req never asserted.
REQ-022 alloc_valid=0 in WAIT -> fail pulse, no bram_we, no commit_req.
REQ-023 rst_n low after 3 of 4 elements of a 2x2 store -> outputs 0, no commit_req; the next request is granted normally.
REQ-024 With STORE_TIMEOUT_EN, elem_valid held low for 255 cycles in WRITE -> fail pulse, no commit_req.
